fifo_burst_rd_controller: RTL and testbench

Parametrised successor of the single-channel 1-KB FIFO drain controller. It watches the stream FIFO fill level and announces a burst to the SDRAM write side. It then issues exactly burst_words FIFO read requests, paced by sdram_rx_rdy. It adds a `>=` threshold (not equality), a flush mode for partial bursts, pause/resume, an inter-burst guard gap, underrun protection and status counters.

---
 rtl/fifo_sdram_pkg.sv | 16 +
 rtl/fifo_burst_rd_controller.sv | 129 ++++++++++++
 tb/tb_fifo_burst_rd_controller.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sdram_pkg.sv
// Shared types and defaults for the stream-FIFO to SDRAM drain path.
package fifo_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int BURST_LEN_DEFAULT  = 512;
    localparam int GAP_CYCLES_DEFAULT = 2;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

endpackage

// File: rtl/fifo_burst_rd_controller.sv
// Drains the stream FIFO in bursts of BURST_LEN words (or a flushed partial fill) towards SDRAM.
// Latency: fifo_tx_rdy one cycle after threshold/flush; each rdreq one cycle after sdram_rx_rdy.
// Backpressure: sdram_rx_rdy low or fifo_empty high stalls rdreq; remaining count holds.
module fifo_burst_rd_controller
    import fifo_sdram_pkg::*;
#(
    parameter int USEDW_W    = 10,
    parameter int BURST_LEN  = BURST_LEN_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [USEDW_W-1:0] fifo_usedw,
    input  logic               fifo_empty,
    input  logic               flush,
    input  logic               sdram_rx_rdy,
    output logic               fifo_tx_rdy,
    output logic               fifo_rdreq,
    output logic [USEDW_W-1:0] burst_words,
    output logic               burst_done,
    output logic [CNT_W-1:0]   bursts_total,
    output logic               underrun_err
);

    if (BURST_LEN < 1 || BURST_LEN >= (2 ** USEDW_W)) begin : g_bad_burst_len
        $error("BURST_LEN must be in 1..2**USEDW_W-1");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap_cycles
        $error("GAP_CYCLES must be in 1..15");
    end

    localparam logic [USEDW_W-1:0] BURST_LEN_V = USEDW_W'(BURST_LEN);
    // GAP lasts GAP_CYCLES cycles including the burst_done cycle, so load N-1.
    localparam logic [3:0]         GAP_LOAD    = 4'(GAP_CYCLES - 1);

    state_t             state, state_nxt;
    logic [USEDW_W-1:0] remaining, remaining_nxt;
    logic [USEDW_W-1:0] burst_words_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic               tx_rdy_nxt;
    logic               rdreq_nxt;
    logic               done_nxt;
    logic               underrun_nxt;
    logic [CNT_W-1:0]   total_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            gap_cnt      <= '0;
            fifo_tx_rdy  <= OFF;
            fifo_rdreq   <= OFF;
            burst_words  <= '0;
            burst_done   <= OFF;
            bursts_total <= '0;
            underrun_err <= OFF;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            gap_cnt      <= gap_cnt_nxt;
            fifo_tx_rdy  <= tx_rdy_nxt;
            fifo_rdreq   <= rdreq_nxt;
            burst_words  <= burst_words_nxt;
            burst_done   <= done_nxt;
            bursts_total <= total_nxt;
            underrun_err <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        remaining_nxt   = remaining;
        gap_cnt_nxt     = gap_cnt;
        tx_rdy_nxt      = fifo_tx_rdy;
        rdreq_nxt       = OFF;
        done_nxt        = OFF;
        burst_words_nxt = burst_words;
        total_nxt       = bursts_total;
        underrun_nxt    = underrun_err;

        case (state)
            IDLE: begin
                // A full burst takes priority over a flush-triggered partial one.
                if (fifo_usedw >= BURST_LEN_V) begin
                    remaining_nxt   = BURST_LEN_V;
                    burst_words_nxt = BURST_LEN_V;
                    tx_rdy_nxt      = ON;
                    state_nxt       = BURST;
                end else if (flush && fifo_usedw != '0) begin
                    remaining_nxt   = fifo_usedw;
                    burst_words_nxt = fifo_usedw;
                    tx_rdy_nxt      = ON;
                    state_nxt       = BURST;
                end
            end

            BURST: begin
                if (remaining == '0) begin
                    state_nxt   = GAP;
                    tx_rdy_nxt  = OFF;
                    done_nxt    = ON;
                    total_nxt   = bursts_total + CNT_W'(1);
                    gap_cnt_nxt = GAP_LOAD;
                end else if (sdram_rx_rdy) begin
                    if (!fifo_empty) begin
                        rdreq_nxt     = ON;
                        remaining_nxt = remaining - USEDW_W'(1);
                    end else begin
                        underrun_nxt  = ON;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_burst_rd_controller.sv
// Scoreboard bench for fifo_burst_rd_controller: default build plus a small 8-word build.
module tb_fifo_burst_rd_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] fifo_usedw;
    logic       fifo_empty, flush, sdram_rx_rdy;
    logic       fifo_tx_rdy, fifo_rdreq, burst_done, underrun_err;
    logic [9:0] burst_words;
    logic [15:0] bursts_total;

    logic [3:0] p_usedw;
    logic       p_empty, p_flush, p_rdy;
    logic       p_tx_rdy, p_rdreq, p_done, p_underrun;
    logic [3:0] p_burst_words;
    logic [1:0] p_total;

    int checks   = 0;
    int failures = 0;
    int exp_total = 0;
    int exp_len_q[$];
    int exp_total_q[$];

    always #5 clk = ~clk;

    fifo_burst_rd_controller u_dut (
        .clk(clk), .rst(rst), .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty),
        .flush(flush), .sdram_rx_rdy(sdram_rx_rdy), .fifo_tx_rdy(fifo_tx_rdy),
        .fifo_rdreq(fifo_rdreq), .burst_words(burst_words), .burst_done(burst_done),
        .bursts_total(bursts_total), .underrun_err(underrun_err)
    );

    fifo_burst_rd_controller #(.USEDW_W(4), .BURST_LEN(8), .GAP_CYCLES(2), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .fifo_usedw(p_usedw), .fifo_empty(p_empty),
        .flush(p_flush), .sdram_rx_rdy(p_rdy), .fifo_tx_rdy(p_tx_rdy),
        .fifo_rdreq(p_rdreq), .burst_words(p_burst_words), .burst_done(p_done),
        .bursts_total(p_total), .underrun_err(p_underrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until burst_done, counting rdreq cycles on the way.
    task automatic run_to_done(input int budget, output int nreq, output bit seen);
        nreq = 0;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (fifo_rdreq) nreq++;
            if (burst_done) seen = 1'b1;
        end
    endtask

    // Ticks until target rdreq cycles have been observed.
    task automatic count_to(input int target, input int budget, output int nreq, output bit ok);
        nreq = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (fifo_rdreq) nreq++;
            if (nreq == target) ok = 1'b1;
        end
    endtask

    task automatic launch_push(input int len);
        exp_len_q.push_back(len);
        exp_total = exp_total + 1;
        exp_total_q.push_back(exp_total);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        fifo_usedw = '0; fifo_empty = 1'b0; flush = 1'b0; sdram_rx_rdy = 1'b0;
        p_usedw = '0; p_empty = 1'b0; p_flush = 1'b0; p_rdy = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL reset_tx_rdy: got %0b expected 0", fifo_tx_rdy); end
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq: got %0b expected 0", fifo_rdreq); end
        checks++; if (burst_words !== 10'd0) begin failures++; $display("FAIL reset_burst_words: got %0d expected 0", burst_words); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL reset_burst_done: got %0b expected 0", burst_done); end
        checks++; if (bursts_total !== 16'd0) begin failures++; $display("FAIL reset_total: got %0d expected 0", bursts_total); end
        checks++; if (underrun_err !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %0b expected 0", underrun_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_burst;
        int nreq, holes, exp_len, exp_tot, tx_hi;
        bit started, seen;
        sdram_rx_rdy = 1'b1; fifo_empty = 1'b0; fifo_usedw = 10'd0;
        repeat (2) tick();
        fifo_usedw = 10'd511;
        repeat (3) tick();
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL below_threshold_tx: got %0b expected 0", fifo_tx_rdy); end
        fifo_usedw = 10'd512;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL full_launch_tx: got %0b expected 1", fifo_tx_rdy); end
        checks++; if (burst_words !== 10'd512) begin failures++; $display("FAIL full_burst_words: got %0d expected 512", burst_words); end
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL full_first_rdreq_early: got %0b expected 0", fifo_rdreq); end
        launch_push(512);
        nreq = 0; holes = 0; started = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (fifo_rdreq) begin nreq++; started = 1'b1; end
            else if (started && !burst_done) holes++;
            if (burst_done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL full_done_timeout: got %0b expected 1", seen); end
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (nreq != exp_len) begin failures++; $display("FAIL full_rdreq_count: got %0d expected %0d", nreq, exp_len); end
        checks++; if (holes != 0) begin failures++; $display("FAIL full_contiguous: got %0d holes expected 0", holes); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL full_total: got %0d expected %0d", bursts_total, exp_tot); end
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL full_done_tx: got %0b expected 0", fifo_tx_rdy); end
        // Threshold still met, but GAP must keep fifo_tx_rdy low.
        tick();
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %0b expected 0", burst_done); end
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL gap1_tx: got %0b expected 0", fifo_tx_rdy); end
        tick();
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL gap2_tx: got %0b expected 0", fifo_tx_rdy); end
        fifo_usedw = 10'd0;
        tx_hi = 0;
        repeat (4) begin tick(); if (fifo_tx_rdy) tx_hi++; end
        checks++; if (tx_hi != 0) begin failures++; $display("FAIL idle_after_gap_tx: got %0d expected 0", tx_hi); end
    endtask

    task automatic test_pause;
        int nreq, low_req, exp_len, exp_tot;
        bit ok, seen;
        fifo_usedw = 10'd512; flush = 1'b0; sdram_rx_rdy = 1'b1;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL pause_launch_tx: got %0b expected 1", fifo_tx_rdy); end
        launch_push(512);
        fifo_usedw = 10'd3;
        count_to(100, 400, nreq, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pause_reach_100: got %0d expected 100", nreq); end
        sdram_rx_rdy = 1'b0;
        tick();
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL pause_stop: got %0b expected 0", fifo_rdreq); end
        low_req = 0;
        repeat (9) begin tick(); if (fifo_rdreq) low_req++; end
        checks++; if (low_req != 0) begin failures++; $display("FAIL pause_hold: got %0d expected 0", low_req); end
        sdram_rx_rdy = 1'b1;
        run_to_done(2000, nreq, seen);
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL pause_done_timeout: got %0b expected 1", seen); end
        checks++; if (nreq != exp_len - 100) begin failures++; $display("FAIL pause_resume_count: got %0d expected %0d", nreq, exp_len - 100); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL pause_total: got %0d expected %0d", bursts_total, exp_tot); end
        repeat (4) tick();
    endtask

    task automatic test_flush;
        int nreq, tx_hi, exp_len, exp_tot;
        bit seen;
        fifo_usedw = 10'd37; flush = 1'b1;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL flush_launch_tx: got %0b expected 1", fifo_tx_rdy); end
        checks++; if (burst_words !== 10'd37) begin failures++; $display("FAIL flush_burst_words: got %0d expected 37", burst_words); end
        launch_push(37);
        fifo_usedw = 10'd0;
        run_to_done(500, nreq, seen);
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL flush_done_timeout: got %0b expected 1", seen); end
        checks++; if (nreq != exp_len) begin failures++; $display("FAIL flush_rdreq_count: got %0d expected %0d", nreq, exp_len); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL flush_total: got %0d expected %0d", bursts_total, exp_tot); end
        // flush still high with an empty FIFO must not start anything.
        tx_hi = 0;
        repeat (8) begin tick(); if (fifo_tx_rdy) tx_hi++; end
        checks++; if (tx_hi != 0) begin failures++; $display("FAIL flush_zero_no_burst: got %0d expected 0", tx_hi); end
        flush = 1'b0;
    endtask

    task automatic test_priority;
        int nreq, exp_len, exp_tot;
        bit seen;
        fifo_usedw = 10'd600; flush = 1'b1;
        tick();
        checks++; if (burst_words !== 10'd512) begin failures++; $display("FAIL priority_burst_words: got %0d expected 512", burst_words); end
        launch_push(512);
        fifo_usedw = 10'd0; flush = 1'b0;
        run_to_done(2000, nreq, seen);
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (nreq != exp_len) begin failures++; $display("FAIL priority_rdreq_count: got %0d expected %0d (done=%0b)", nreq, exp_len, seen); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL priority_total: got %0d expected %0d", bursts_total, exp_tot); end
        repeat (4) tick();
    endtask

    task automatic test_underrun;
        int nreq, low_req, exp_len, exp_tot;
        bit ok, seen;
        checks++; if (underrun_err !== 1'b0) begin failures++; $display("FAIL underrun_before: got %0b expected 0", underrun_err); end
        fifo_usedw = 10'd512;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL underrun_launch_tx: got %0b expected 1", fifo_tx_rdy); end
        launch_push(512);
        fifo_usedw = 10'd0;
        count_to(200, 600, nreq, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL underrun_reach_200: got %0d expected 200", nreq); end
        fifo_empty = 1'b1;
        tick();
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL underrun_stop: got %0b expected 0", fifo_rdreq); end
        checks++; if (underrun_err !== 1'b1) begin failures++; $display("FAIL underrun_flag: got %0b expected 1", underrun_err); end
        low_req = 0;
        repeat (5) begin tick(); if (fifo_rdreq) low_req++; end
        checks++; if (low_req != 0) begin failures++; $display("FAIL underrun_hold: got %0d expected 0", low_req); end
        fifo_empty = 1'b0;
        run_to_done(2000, nreq, seen);
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (nreq != exp_len - 200) begin failures++; $display("FAIL underrun_resume_count: got %0d expected %0d (done=%0b)", nreq, exp_len - 200, seen); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL underrun_total: got %0d expected %0d", bursts_total, exp_tot); end
        checks++; if (underrun_err !== 1'b1) begin failures++; $display("FAIL underrun_sticky: got %0b expected 1", underrun_err); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_burst;
        int nreq, exp_len, exp_tot;
        bit ok, seen;
        fifo_usedw = 10'd512;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_launch_tx: got %0b expected 1", fifo_tx_rdy); end
        fifo_usedw = 10'd0;
        count_to(300, 800, nreq, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_reach_300: got %0d expected 300", nreq); end
        rst = 1'b1;
        tick();
        exp_total = 0;
        checks++; if (fifo_tx_rdy !== 1'b0) begin failures++; $display("FAIL rstmid_tx: got %0b expected 0", fifo_tx_rdy); end
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL rstmid_rdreq: got %0b expected 0", fifo_rdreq); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %0b expected 0", burst_done); end
        checks++; if (burst_words !== 10'd0) begin failures++; $display("FAIL rstmid_burst_words: got %0d expected 0", burst_words); end
        checks++; if (bursts_total !== 16'd0) begin failures++; $display("FAIL rstmid_total: got %0d expected 0", bursts_total); end
        checks++; if (underrun_err !== 1'b0) begin failures++; $display("FAIL rstmid_underrun: got %0b expected 0", underrun_err); end
        rst = 1'b0;
        fifo_usedw = 10'd600;
        tick();
        checks++; if (fifo_tx_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_relaunch_tx: got %0b expected 1", fifo_tx_rdy); end
        launch_push(512);
        fifo_usedw = 10'd0;
        run_to_done(2000, nreq, seen);
        exp_len = exp_len_q.pop_front();
        exp_tot = exp_total_q.pop_front();
        checks++; if (nreq != exp_len) begin failures++; $display("FAIL rstmid_fresh_count: got %0d expected %0d (done=%0b)", nreq, exp_len, seen); end
        checks++; if (bursts_total !== 16'(exp_tot)) begin failures++; $display("FAIL rstmid_fresh_total: got %0d expected %0d", bursts_total, exp_tot); end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back;
        int exp_seq[5];
        int p_len_q[$];
        int p_tot_q[$];
        int cur, ndone, launches, idle_run, short_gaps, exp_len, exp_tot;
        bit prev_tx;
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; exp_seq[4] = 1;
        cur = 0; ndone = 0; launches = 0; idle_run = 0; short_gaps = 0; prev_tx = 1'b0;
        p_rdy = 1'b1; p_empty = 1'b0; p_flush = 1'b0; p_usedw = 4'd15;
        for (int i = 0; i < 400 && ndone < 5; i++) begin
            tick();
            if (p_tx_rdy && !prev_tx && launches < 5) begin
                p_len_q.push_back(8);
                p_tot_q.push_back(exp_seq[launches]);
                launches++;
            end
            prev_tx = p_tx_rdy;
            if (p_rdreq) begin
                if (ndone > 0 && cur == 0 && idle_run < 2) short_gaps++;
                cur++;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (p_done) begin
                exp_len = p_len_q.pop_front();
                exp_tot = p_tot_q.pop_front();
                checks++; if (cur != exp_len) begin failures++; $display("FAIL b2b_rdreq_count[%0d]: got %0d expected %0d", ndone, cur, exp_len); end
                checks++; if (p_total !== 2'(exp_tot)) begin failures++; $display("FAIL b2b_total[%0d]: got %0d expected %0d", ndone, p_total, exp_tot); end
                cur = 0;
                ndone++;
                if (ndone == 5) p_usedw = 4'd0;
            end
        end
        checks++; if (ndone != 5) begin failures++; $display("FAIL b2b_burst_count: got %0d expected 5", ndone); end
        checks++; if (short_gaps != 0) begin failures++; $display("FAIL b2b_gap: got %0d short gaps expected 0", short_gaps); end
        repeat (4) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_pause();
        test_flush();
        test_priority();
        test_underrun();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
